dmem_sync: RTL and testbench
============================

# dmem_sync

Parametrised, synchronous data memory for the KGP-RISC datapath; it is the successor to the single-cycle combinational-read data memory. It adds configurable width and depth, byte-lane write strobes, a valid/ready request channel with a registered one-cycle response, range and alignment checking, and a sequenced post-reset/soft clear. It sits between the execute/memory stage and the load/store writeback path.

## Interface
- DATA_W, 32: word width in bits; multiple of 8, at least 8.
- DEPTH, 64: number of words; power of two, at least 2.
- ADDR_W, 32: byte-address width.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = in reset).
- clr  in  1  synchronous request to re-zero the whole array.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when both req_valid and req_ready are 1 at a rising edge.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte-lane write enables; ignored on reads.
- resp_valid  out  1  response for the request accepted on the previous edge.
- resp_rdata  out  DATA_W  read data; 0 for writes and errored reads.
- resp_err  out  1  accepted request was misaligned or out of range.
- init_done  out  1  array clear complete; block is serving requests.

## Operation
- Definitions: BYTES = DATA_W/8, OFF_W = log2(BYTES), IDX_W = log2(DEPTH).
- Word index is req_addr[OFF_W +: IDX_W].
- A request is an error if req_addr[OFF_W-1:0] != 0, or if req_addr >= DEPTH*BYTES.
- States are CLEAR and RUN, with an IDX_W-bit clear counter.
- In reset: state = CLEAR, counter = 0. Outputs reset to req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0, init_done = 0.
- CLEAR:
  - Each edge writes 0 to word[counter] and increments the counter.
  - On the edge that writes word DEPTH-1, go to RUN and set init_done = 1.
  - req_ready = 0 throughout.
- RUN:
  - req_ready = !clr, so one request can be accepted per cycle with no bubbles.
  - Accepted write without error: for each lane b with req_be[b] = 1, update byte b. Other lanes keep their value. The response has resp_rdata = 0 and resp_err = 0.
  - Accepted write with error: the array is unchanged; resp_err = 1.
  - Accepted read without error: resp_rdata = the word value before this edge; resp_err = 0.
  - Accepted read with error: resp_rdata = 0; resp_err = 1.
  - req_be = 0 on a write is legal: nothing changes and the write is still acknowledged.
- clr = 1 in RUN:
  - No request is accepted that cycle.
  - At the edge: counter = 0, state = CLEAR, init_done = 0.
  - A response already in flight still completes on that edge.
- clr is ignored while in CLEAR; it does not restart the sequence.
- Reset asserted mid-operation discards any pending response. Array contents are not guaranteed until the clear sequence finishes.

## Timing
- The block is rising-edge only. There is no negedge write.
- Response latency is exactly 1 cycle: a request accepted at edge N has its response valid between edges N and N+1.
- resp_valid is a single-cycle pulse per accepted request. There is no response backpressure.
- When no request is accepted, resp_valid = 0 and resp_rdata and resp_err return to 0.
- Back-to-back write then read to the same word: the read is accepted one edge later and returns the new data.
- After rst is released, req_ready first rises after exactly DEPTH rising edges. The same holds after clr.

## Structure
- Shared package dmem_pkg holds:
  - the state enum (ST_CLEAR, ST_RUN);
  - a function clog2;
  - the function addr_err(addr), parametrised by BYTES and DEPTH.
- Sub-module dmem_array holds the storage: single port, synchronous read, byte-enable write, with inputs we, be, idx, wdata and output rdata. It has no reset, so it infers as RAM.
- The top level holds the FSM, the clear counter, the error check and the response registers.

## Test plan
- Release reset with DEPTH=64: req_ready = 0 for 64 edges, then 1 with init_done = 1. A read of address 0x0FC then returns 0 with resp_err = 0.
- Write 0xDEADBEEF to address 0x10 with be = 4'b1111, then write 0x000000AA with be = 4'b0001, then read 0x10 → resp_rdata = 0xDEADBEAA, each response exactly 1 cycle after acceptance.
- Misaligned read at 0x12 → resp_err = 1 and resp_rdata = 0. Write to 0x100 (out of range) → resp_err = 1, and a later read of 0x000 shows no change.
- Stream 8 writes followed by 8 reads with req_valid held high → 16 consecutive resp_valid pulses with correct data and no stalls.
- Assert clr in the same cycle as req_valid (a write) → that write is not accepted. Then 64 cycles with req_ready = 0, after which every word reads back 0.
- Assert rst low mid-stream → all outputs go to 0 immediately (asynchronous). After release, the 64-cycle clear runs again.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the synchronous data memory.
// Holds the FSM state encoding, a constant-time log2, and the request range/alignment check.
package dmem_pkg;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   function automatic int unsigned clog2(input int unsigned val);
      int unsigned res;
      res = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(val)) res = i + 1;
      end
      return res;
   endfunction

   // Misaligned (nonzero byte offset) or beyond the last byte of the array.
   function automatic logic addr_err(input logic [63:0] addr,
                                     input int unsigned bytes,
                                     input int unsigned depth);
      logic [63:0] w_mask;
      logic [63:0] w_lim;
      w_mask = 64'(bytes) - 64'd1;
      w_lim  = 64'(bytes) * 64'(depth);
      return ((addr & w_mask) != 64'd0) || (addr >= w_lim);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous read-before-write, byte-lane write enables.
// Deliberately has no reset so it maps onto a RAM macro.
module dmem_array #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned IDX_W  = 6
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DATA_W/8-1:0]   be,
   input  logic [IDX_W-1:0]      idx,
   input  logic [DATA_W-1:0]     wdata,
   output logic [DATA_W-1:0]     rdata
);

   localparam int unsigned BYTES = DATA_W / 8;

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      rdata <= r_mem[idx];
      if (we) begin
         for (int b = 0; b < int'(BYTES); b++) begin
            if (be[b]) r_mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/dmem_sync.sv
// Synchronous data memory with valid/ready request channel and one-cycle registered response.
// A clear sequence zeroes every word after reset or on clr before requests are served.
module dmem_sync
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned ADDR_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [DATA_W/8-1:0]   req_be,
   output logic                  resp_valid,
   output logic [DATA_W-1:0]     resp_rdata,
   output logic                  resp_err,
   output logic                  init_done
);

   localparam int unsigned BYTES = DATA_W / 8;
   localparam int unsigned OFF_W = clog2(BYTES);
   localparam int unsigned IDX_W = clog2(DEPTH);

   state_t               r_state;
   state_t               w_state_nx;
   logic [IDX_W-1:0]     r_cnt;
   logic [IDX_W-1:0]     w_cnt_nx;
   logic                 r_init_done;
   logic                 w_init_nx;
   logic                 r_resp_valid;
   logic                 r_resp_err;
   logic                 r_rd_ok;
   logic                 w_resp_valid_nx;
   logic                 w_resp_err_nx;
   logic                 w_rd_ok_nx;

   logic                 w_acc;
   logic                 w_err;
   logic [IDX_W-1:0]     w_req_idx;

   logic                 w_mem_we;
   logic [BYTES-1:0]     w_mem_be;
   logic [IDX_W-1:0]     w_mem_idx;
   logic [DATA_W-1:0]    w_mem_wdata;
   logic [DATA_W-1:0]    w_mem_rdata;

   assign req_ready = (r_state == ST_RUN) && !clr;
   assign w_acc     = req_valid && req_ready;
   assign w_err     = addr_err(64'(req_addr), BYTES, DEPTH);
   assign w_req_idx = req_addr[OFF_W +: IDX_W];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_CLEAR;
         r_cnt        <= '0;
         r_init_done  <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_rd_ok      <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_cnt        <= w_cnt_nx;
         r_init_done  <= w_init_nx;
         r_resp_valid <= w_resp_valid_nx;
         r_resp_err   <= w_resp_err_nx;
         r_rd_ok      <= w_rd_ok_nx;
      end
   end

   always_comb begin
      w_state_nx      = r_state;
      w_cnt_nx        = r_cnt;
      w_init_nx       = r_init_done;
      w_mem_we        = 1'b0;
      w_mem_be        = '0;
      w_mem_idx       = w_req_idx;
      w_mem_wdata     = req_wdata;
      w_resp_valid_nx = w_acc;
      w_resp_err_nx   = w_acc && w_err;
      w_rd_ok_nx      = w_acc && !req_we && !w_err;

      case (r_state)
         ST_CLEAR: begin
            w_mem_we    = 1'b1;
            w_mem_be    = '1;
            w_mem_idx   = r_cnt;
            w_mem_wdata = '0;
            w_cnt_nx    = r_cnt + IDX_W'(1);
            if (r_cnt == IDX_W'(DEPTH - 1)) begin
               w_state_nx = ST_RUN;
               w_init_nx  = 1'b1;
            end
         end
         ST_RUN: begin
            if (clr) begin
               w_state_nx = ST_CLEAR;
               w_cnt_nx   = '0;
               w_init_nx  = 1'b0;
            end else if (w_acc && req_we && !w_err) begin
               w_mem_we = 1'b1;
               w_mem_be = req_be;
            end
         end
         default: begin
            w_state_nx = ST_CLEAR;
            w_cnt_nx   = '0;
            w_init_nx  = 1'b0;
         end
      endcase
   end

   dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (w_mem_we),
      .be    (w_mem_be),
      .idx   (w_mem_idx),
      .wdata (w_mem_wdata),
      .rdata (w_mem_rdata)
   );

   // RAM output is only exposed for a clean read; writes, errors and idle cycles show 0.
   assign resp_rdata = w_mem_rdata & {DATA_W{r_rd_ok}};
   assign resp_valid = r_resp_valid;
   assign resp_err   = r_resp_err;
   assign init_done  = r_init_done;

endmodule

// File: tb/tb_dmem_sync.sv
// Directed bench for dmem_sync (DATA_W=32, DEPTH=64): clear timing, byte lanes, errors, streaming, clr, reset.
module tb_dmem_sync;

   logic        clk;
   logic        rst;
   logic        clr;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        init_done;

   int n_err = 0;
   int n_chk = 0;

   dmem_sync #(.DATA_W(32), .DEPTH(64), .ADDR_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_be     (req_be),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .init_done  (init_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Counts edges until req_ready rises, bounded so a stuck DUT still reaches the summary.
   task automatic wait_ready(input string tag);
      int cycles;
      cycles = 0;
      while (req_ready !== 1'b1 && cycles < 200) begin
         @(posedge clk); #1;
         cycles++;
      end
      chk(tag, 32'(cycles), 32'd64);
      chk({tag, "_init"}, 32'(init_done), 32'd1);
   endtask

   // One accepted request followed by its response check one edge later.
   task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] exp_rdata, input logic exp_err);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      #1;
      chk({tag, "_ready"}, 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk({tag, "_rv"}, 32'(resp_valid), 32'd1);
      chk({tag, "_rdata"}, resp_rdata, exp_rdata);
      chk({tag, "_err"}, 32'(resp_err), 32'(exp_err));
   endtask

   task automatic idle_chk(input string tag);
      @(posedge clk); #1;
      chk({tag, "_rv"}, 32'(resp_valid), 32'd0);
      chk({tag, "_rdata"}, resp_rdata, 32'd0);
      chk({tag, "_err"}, 32'(resp_err), 32'd0);
   endtask

   initial begin
      rst = 1'b0; clr = 1'b0; req_valid = 1'b0; req_we = 1'b0;
      req_addr = '0; req_wdata = '0; req_be = '0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_rv", 32'(resp_valid), 32'd0);
      chk("rst_init", 32'(init_done), 32'd0);
      chk("rst_err", 32'(resp_err), 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      rst = 1'b1;
      wait_ready("clear_after_rst");

      do_req("rd_fc", 1'b0, 32'h0FC, 32'h0, 4'hF, 32'h0, 1'b0);

      // byte lanes, back-to-back write then read
      do_req("wr_full", 1'b1, 32'h010, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0);
      do_req("wr_b0",   1'b1, 32'h010, 32'h000000AA, 4'b0001, 32'h0, 1'b0);
      do_req("rd_10",   1'b0, 32'h010, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);
      do_req("wr_be0",  1'b1, 32'h010, 32'h11223344, 4'b0000, 32'h0, 1'b0);
      do_req("rd_10b",  1'b0, 32'h010, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);
      do_req("wr_b2",   1'b1, 32'h014, 32'h55667788, 4'b0100, 32'h0, 1'b0);
      do_req("rd_14",   1'b0, 32'h014, 32'h0, 4'h0, 32'h00660000, 1'b0);
      idle_chk("idle1");

      // errors
      do_req("rd_mis",  1'b0, 32'h012, 32'h0, 4'h0, 32'h0, 1'b1);
      do_req("wr_oor",  1'b1, 32'h100, 32'h12345678, 4'hF, 32'h0, 1'b1);
      do_req("rd_0",    1'b0, 32'h000, 32'h0, 4'h0, 32'h0, 1'b0);
      do_req("wr_mis",  1'b1, 32'h011, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
      do_req("rd_10c",  1'b0, 32'h010, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);
      do_req("rd_hi",   1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h0, 1'b1);

      // stream 8 writes then 8 reads without deasserting req_valid
      for (int i = 0; i < 16; i++) begin
         req_valid = 1'b1;
         req_we    = (i < 8);
         req_addr  = 32'h020 + 32'((i % 8) * 4);
         req_wdata = 32'h1000_0000 + 32'(i % 8) * 32'h0111_1111;
         req_be    = 4'hF;
         #1;
         chk("stream_ready", 32'(req_ready), 32'd1);
         @(posedge clk); #1;
         chk("stream_rv", 32'(resp_valid), 32'd1);
         chk("stream_rdata", resp_rdata,
             (i < 8) ? 32'h0 : 32'h1000_0000 + 32'(i % 8) * 32'h0111_1111);
         chk("stream_err", 32'(resp_err), 32'd0);
      end
      req_valid = 1'b0;
      idle_chk("idle2");

      // clr in the same cycle as a write: write is refused, array re-zeroed
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h020;
      req_wdata = 32'hFFFFFFFF; req_be = 4'hF; clr = 1'b1;
      #1;
      chk("clr_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      clr = 1'b0; req_valid = 1'b0;
      chk("clr_rv", 32'(resp_valid), 32'd0);
      chk("clr_init", 32'(init_done), 32'd0);
      wait_ready("clear_after_clr");
      for (int i = 0; i < 64; i++) begin
         do_req("clr_zero", 1'b0, 32'(i * 4), 32'h0, 4'h0, 32'h0, 1'b0);
      end

      // asynchronous reset while a read response is on the outputs
      do_req("wr_40", 1'b1, 32'h040, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h040;
      @(posedge clk); #1;
      chk("pre_rst_rdata", resp_rdata, 32'hCAFEF00D);
      req_valid = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk("arst_rv", 32'(resp_valid), 32'd0);
      chk("arst_rdata", resp_rdata, 32'd0);
      chk("arst_ready", 32'(req_ready), 32'd0);
      chk("arst_init", 32'(init_done), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      wait_ready("clear_after_rst2");
      do_req("rd_40", 1'b0, 32'h040, 32'h0, 4'h0, 32'h0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
